dmem_responder: RTL and testbench

//  Data-memory responder on the far end of the MEM-stage request interface of the 8-bit pipelined core.

---
 rtl/dmem_responder_if.sv | 31 +++
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Request/response bundle between the MEM stage and the data-memory
//   responder. Parameters must match the responder they connect to.
//   MEM-stage side (master) drives:
//     flush, req_read, req_write, req_addr, req_wdata
//   Responder side (slave) drives:
//     req_ready, stall, resp_valid, resp_rdata
interface dmem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              flush;
  logic              req_read;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              stall;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output flush, req_read, req_write, req_addr, req_wdata,
    input  req_ready, stall, resp_valid, resp_rdata
  );

  modport slave (
    input  flush, req_read, req_write, req_addr, req_wdata,
    output req_ready, stall, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the 8-bit pipelined core. Owns a DEPTH x DATA_W
//   array. Stores commit at the accepting edge with no stall; loads return
//   RD_LAT cycles after acceptance as a one-cycle resp_valid pulse, with stall
//   held high until then so IF/ID/EX/MEM freeze.
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears FSM, counter, read data and memory
//   bus    dmem_responder_if.slave (flush, req_*, req_ready, stall, resp_*)
// Parameters
//   ADDR_W address width (DEPTH = 2**ADDR_W), DATA_W word width,
//   RD_LAT load latency, legal 1..4.
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, RBUSY, RESP} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [ADDR_W-1:0]   addr_q, addr_nx;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_en;
  logic                rd_fetch;
  logic [ADDR_W-1:0]   fetch_addr;

  // Next-state / output decode. Outputs that depend on the strobes (stall)
  // are combinational so the hazard unit sees the freeze in the accept cycle.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    addr_nx        = addr_q;
    wr_en          = 1'b0;
    rd_fetch       = 1'b0;
    fetch_addr     = addr_q;
    bus.req_ready  = 1'b0;
    bus.stall      = 1'b0;
    bus.resp_valid = 1'b0;

    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (!bus.flush) begin
          // A store wins over a simultaneous load.
          if (bus.req_write) begin
            wr_en = 1'b1;
          end else if (bus.req_read) begin
            bus.stall = 1'b1;
            addr_nx   = bus.req_addr;
            cnt_nx    = CNT_W'(RD_LAT - 1);
            if (RD_LAT > 1) begin
              state_nx = RBUSY;
            end else begin
              // Single-cycle latency: data must be captured at this edge.
              state_nx   = RESP;
              rd_fetch   = 1'b1;
              fetch_addr = bus.req_addr;
            end
          end
        end
      end

      RBUSY: begin
        if (bus.flush) begin
          // Abort: release the pipeline now, never respond.
          state_nx = IDLE;
        end else begin
          bus.stall = 1'b1;
          cnt_nx    = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_nx = RESP;
            rd_fetch = 1'b1;
          end
        end
      end

      RESP: begin
        // The load has completed, so a flush here does not cancel it.
        bus.resp_valid = 1'b1;
        state_nx       = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  assign bus.resp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      addr_q <= addr_nx;
      if (wr_en)    mem[bus.req_addr] <= bus.req_wdata;
      // Read data is only refreshed on entry to RESP; it holds otherwise.
      if (rd_fetch) rdata_q <= mem[fetch_addr];
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: DUT A uses RD_LAT=2, DUT B uses RD_LAT=1.
// A row table drives one DUT per cycle; load data is checked through a
// scoreboard fed from a reference memory when a load is accepted.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
  dmem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

  logic       rst_v  [2];
  logic       fl_v   [2];
  logic       rd_v   [2];
  logic       wr_v   [2];
  logic [7:0] addr_v [2];
  logic [7:0] wd_v   [2];

  assign bus_a.flush     = fl_v[0];
  assign bus_a.req_read  = rd_v[0];
  assign bus_a.req_write = wr_v[0];
  assign bus_a.req_addr  = addr_v[0];
  assign bus_a.req_wdata = wd_v[0];
  assign bus_b.flush     = fl_v[1];
  assign bus_b.req_read  = rd_v[1];
  assign bus_b.req_write = wr_v[1];
  assign bus_b.req_addr  = addr_v[1];
  assign bus_b.req_wdata = wd_v[1];

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) dut_a (
    .clk(clk), .reset(rst_v[0]), .bus(bus_a.slave));
  dmem_responder #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut_b (
    .clk(clk), .reset(rst_v[1]), .bus(bus_b.slave));

  typedef struct {
    bit         sel;
    bit         rst, fl, rd, wr;
    logic [7:0] addr, wd;
    bit         chk, e_rdy, e_st, e_rv;
    bit         crd;
    logic [7:0] e_rd;
    bit         abort;
  } vec_t;

  vec_t       tbl [$];
  logic [7:0] mdl [2][256];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input bit sel, rst, fl, rd, wr,
                              input logic [7:0] a, wd,
                              input bit chk, rdy, st, rv, crd,
                              input logic [7:0] erd, input bit ab);
    vec_t r;
    r.sel = sel; r.rst = rst; r.fl = fl; r.rd = rd; r.wr = wr;
    r.addr = a; r.wd = wd; r.chk = chk; r.e_rdy = rdy; r.e_st = st;
    r.e_rv = rv; r.crd = crd; r.e_rd = erd; r.abort = ab;
    return r;
  endfunction

  task automatic cmp(input string name, input int row, input logic [7:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  task automatic clear_drv();
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b0; fl_v[k] = 1'b0; rd_v[k] = 1'b0; wr_v[k] = 1'b0;
      addr_v[k] = 8'h00; wd_v[k] = 8'h00;
    end
  endtask

  task automatic clear_model(input bit sel);
    for (int i = 0; i < 256; i++) mdl[sel][i] = 8'h00;
    if (sel) q1.delete(); else q0.delete();
  endtask

  task automatic apply(input vec_t r, input int row);
    logic       a_rdy, a_st, a_rv;
    logic [7:0] a_rd, exp_d;
    @(posedge clk); #1;
    clear_drv();
    rst_v[r.sel] = r.rst; fl_v[r.sel] = r.fl; rd_v[r.sel] = r.rd;
    wr_v[r.sel] = r.wr; addr_v[r.sel] = r.addr; wd_v[r.sel] = r.wd;
    @(negedge clk);
    a_rdy = r.sel ? bus_b.req_ready  : bus_a.req_ready;
    a_st  = r.sel ? bus_b.stall      : bus_a.stall;
    a_rv  = r.sel ? bus_b.resp_valid : bus_a.resp_valid;
    a_rd  = r.sel ? bus_b.resp_rdata : bus_a.resp_rdata;
    if (r.chk) begin
      cmp("req_ready", row, {7'd0, a_rdy}, {7'd0, r.e_rdy});
      cmp("stall", row, {7'd0, a_st}, {7'd0, r.e_st});
      cmp("resp_valid", row, {7'd0, a_rv}, {7'd0, r.e_rv});
    end
    if (r.crd) cmp("rdata_hold", row, a_rd, r.e_rd);
    if (a_rv) begin
      if ((r.sel ? q1.size() : q0.size()) == 0) begin
        cmp("unexpected_resp", row, 8'h01, 8'h00);
      end else begin
        exp_d = r.sel ? q1.pop_front() : q0.pop_front();
        cmp("resp_rdata", row, a_rd, exp_d);
      end
    end
    // Reference model update for this cycle.
    if (r.rst) begin
      clear_model(r.sel);
    end else begin
      if (r.abort) begin
        if (r.sel) void'(q1.pop_front()); else void'(q0.pop_front());
      end
      if (!r.fl && r.e_rdy) begin
        if (r.wr) mdl[r.sel][r.addr] = r.wd;
        else if (r.rd) begin
          if (r.sel) q1.push_back(mdl[1][r.addr]);
          else       q0.push_back(mdl[0][r.addr]);
        end
      end
    end
  endtask

  initial begin
    int   lat, st_cnt;
    bit   got;
    logic [7:0] got_d;

    clear_drv();
    clear_model(0);
    clear_model(1);
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 clear_drv();
    @(negedge clk);
    cmp("rst_ready_a", -1, {7'd0, bus_a.req_ready}, 8'h01);
    cmp("rst_stall_a", -1, {7'd0, bus_a.stall}, 8'h00);
    cmp("rst_rv_a", -1, {7'd0, bus_a.resp_valid}, 8'h00);
    cmp("rst_rdata_a", -1, bus_a.resp_rdata, 8'h00);
    cmp("rst_ready_b", -1, {7'd0, bus_b.req_ready}, 8'h01);
    cmp("rst_rdata_b", -1, bus_b.resp_rdata, 8'h00);

    //            sel rst fl rd wr addr   wd     chk rdy st rv crd erd   ab
    // T1: store then load, RD_LAT=2
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h10, 8'hA5, 1, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h10, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0));
    // T2: read held 4 cycles; RESP does not re-accept, IDLE after it does
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h10, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h10, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h10, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h10, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0));
    // T3: flush in RBUSY aborts the load
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h20, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0));
    // flush in IDLE blocks store and load; flush in RESP keeps the response
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'h20, 8'h99, 1, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 8'h20, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h20, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 1, 8'h00, 0));
    // T4: read+write together is a store; strobe in RBUSY is ignored
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'h30, 8'h5C, 1, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h30, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h30, 8'hEE, 1, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 1, 8'h5C, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h30, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0));
    // T5: reset in RBUSY discards the load and clears memory
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h40, 8'h77, 1, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h40, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 1, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h40, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0));
    // T6: RD_LAT=1 on DUT B, top address, neighbour @0x00 untouched
    tbl.push_back(mk(1, 0, 0, 0, 1, 8'hFF, 8'h3C, 1, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 8'hFF, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 1, 8'h00, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Back-to-back store/load at 0xFF on DUT A with the MEM stage holding
    // req_read while stalled; measure latency and stall length.
    @(posedge clk); #1;
    clear_drv();
    wr_v[0] = 1'b1; addr_v[0] = 8'hFF; wd_v[0] = 8'hC3;
    @(posedge clk); #1;
    clear_drv();
    rd_v[0] = 1'b1; addr_v[0] = 8'hFF;
    got = 1'b0; lat = 0; st_cnt = 0; got_d = 8'h00;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (bus_a.stall) st_cnt++;
      else rd_v[0] = 1'b0;
      if (bus_a.resp_valid) begin
        got = 1'b1; lat = c; got_d = bus_a.resp_rdata;
      end
    end
    cmp("seq_resp_seen", 99, {7'd0, got}, 8'h01);
    cmp("seq_latency", 99, 8'(lat), 8'd2);
    cmp("seq_stall_cycles", 99, 8'(st_cnt), 8'd2);
    cmp("seq_rdata", 99, got_d, 8'hC3);
    @(posedge clk); #1;
    clear_drv();
    @(negedge clk);
    cmp("seq_ready_after", 99, {7'd0, bus_a.req_ready}, 8'h01);

    cmp("sb_empty_a", 100, 8'(q0.size()), 8'd0);
    cmp("sb_empty_b", 100, 8'(q1.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
